// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with 8-entry FIFO and drain interrupt
// Optional: define UART_TX_PARITY_EN to add CTRL parity_en/odd and a PARITY bit before STOP.
module uart_tx_mmio #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = 3,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        int_o
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_t             state, state_d;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow, tx_en, int_en;
    logic [15:0]        divisor, div_q, baud_cnt;
    logic [7:0]         shift;
    logic [2:0]         bit_idx;
`ifdef UART_TX_PARITY_EN
    logic               ctrl_par, ctrl_odd, par_en_q, par_q;
`endif

    logic full, empty, busy, wr_en, wr_txdata, wr_status, wr_div, wr_ctrl;
    logic pop, push, bit_end;
    logic unused_bits;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign busy      = (state != S_IDLE);
    assign wr_en     = ce & we & (sel == 4'b1111);
    assign wr_txdata = wr_en & (addr[3:2] == 2'd0);
    assign wr_status = wr_en & (addr[3:2] == 2'd1);
    assign wr_div    = wr_en & (addr[3:2] == 2'd2);
    assign wr_ctrl   = wr_en & (addr[3:2] == 2'd3);
    assign pop       = (state == S_IDLE) & tx_en & ~empty;
    // A full FIFO still accepts the byte when the head is leaving this cycle.
    assign push      = wr_txdata & (~full | pop);
    assign bit_end   = (baud_cnt == div_q - 16'd1);
    assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16]};

    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (pop) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA:   if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                          state_d = par_en_q ? S_PARITY : S_STOP;
`else
                          state_d = S_STOP;
`endif
                      end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (state)
            S_START:  txd = 1'b0;
            S_DATA:   txd = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd = par_q;
`endif
            default:  txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divisor  <= DIV_RESET;
            tx_en    <= 1'b0;
            int_en   <= 1'b0;
            div_q    <= DIV_RESET;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            int_o    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            ctrl_par <= 1'b0;
            ctrl_odd <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_i[7:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Clear first so a simultaneous dropped byte leaves overflow set.
            if (wr_status && data_i[3]) overflow <= 1'b0;
            if (wr_txdata && full && !pop) overflow <= 1'b1;
            if (wr_div) divisor <= data_i[15:0];
            if (wr_ctrl) begin
                tx_en  <= data_i[0];
                int_en <= data_i[1];
`ifdef UART_TX_PARITY_EN
                ctrl_par <= data_i[2];
                ctrl_odd <= data_i[3];
`endif
            end
            if (pop) begin
                shift    <= mem[rd_ptr];
                div_q    <= (divisor < 16'd2) ? 16'd2 : divisor;
                baud_cnt <= '0;
                bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                par_en_q <= ctrl_par;
                par_q    <= (^mem[rd_ptr]) ^ ctrl_odd;
`endif
            end else if (state != S_IDLE) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    if (state == S_DATA) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 16'd1;
                end
            end
            int_o <= int_en & empty & (state == S_IDLE);
        end
    end

    always_comb begin
        data_o = 32'h0;
        if (ce && !we) begin
            case (addr[3:2])
                2'd1: data_o = {24'h0, count, overflow, busy, empty, full};
                2'd2: data_o = {16'h0, divisor};
`ifdef UART_TX_PARITY_EN
                2'd3: data_o = {28'h0, ctrl_odd, ctrl_par, int_en, tx_en};
`else
                2'd3: data_o = {28'h0, 2'b00, int_en, tx_en};
`endif
                default: data_o = 32'h0;
            endcase
        end
    end
endmodule
